// File: rtl/jtag_tap_sampler_if.sv
// JTAG pin bundle and user data-register strobe bus for jtag_tap_sampler.
// The slave modport is the TAP; the master modport is the JTAG source / debug transport side.
interface jtag_tap_sampler_if #(
    parameter int IR_WIDTH = 5
);
    logic                jtag_TCK;
    logic                jtag_TMS;
    logic                jtag_TDI;
    logic                jtag_TRSTn;
    logic                jtag_TDO_data;
    logic                jtag_TDO_driven;
    logic [3:0]          tap_state;
    logic [IR_WIDTH-1:0] ir_value;
    logic                user_sel;
    logic                dr_capture;
    logic                dr_shift;
    logic                dr_update;
    logic                dr_tdo;

    modport master (
        output jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn, dr_tdo,
        input  jtag_TDO_data, jtag_TDO_driven, tap_state, ir_value,
               user_sel, dr_capture, dr_shift, dr_update
    );

    modport slave (
        input  jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn, dr_tdo,
        output jtag_TDO_data, jtag_TDO_driven, tap_state, ir_value,
               user_sel, dr_capture, dr_shift, dr_update
    );
endinterface

// File: rtl/jtag_tap_sampler.sv
// IEEE 1149.1 TAP controller running in the system clock domain on oversampled JTAG pins,
// with IR, IDCODE and BYPASS registers and a strobe interface to an external user DR.
module jtag_tap_sampler #(
    parameter int          IR_WIDTH     = 5,
    parameter logic [31:0] IDCODE_VALUE = 32'h00000001,
    parameter int          SYNC_STAGES  = 2
) (
    input logic              clock,
    input logic              reset,
    jtag_tap_sampler_if.slave bus
);
    typedef enum logic [3:0] {
        TLR    = 4'hF, RTI    = 4'hC, SEL_DR = 4'h7, CAP_DR = 4'h6,
        SH_DR  = 4'h2, EX1_DR = 4'h1, PAU_DR = 4'h3, EX2_DR = 4'h0,
        UPD_DR = 4'h5, SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA,
        EX1_IR = 4'h9, PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
    } tap_state_t;

    localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] IR_BYPASS = '1;

    logic [SYNC_STAGES-1:0] tck_sync, tms_sync, tdi_sync, trstn_sync;
    logic                   tck_prev;
    logic                   tck, tms, tdi, trst_n, tck_rise, tck_fall;

    tap_state_t          state, state_next;
    logic [IR_WIDTH-1:0] ir_shift, ir_value;
    logic [31:0]         id_shift;
    logic                bypass_bit, tdo_data, tdo_driven, dr_tdo_mux, user_sel;
    logic                dr_capture, dr_shift, dr_update;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tck_sync   <= '0;
            tms_sync   <= '1;
            tdi_sync   <= '0;
            trstn_sync <= '1;
            tck_prev   <= 1'b0;
        end else begin
            tck_sync   <= {tck_sync[SYNC_STAGES-2:0], bus.jtag_TCK};
            tms_sync   <= {tms_sync[SYNC_STAGES-2:0], bus.jtag_TMS};
            tdi_sync   <= {tdi_sync[SYNC_STAGES-2:0], bus.jtag_TDI};
            trstn_sync <= {trstn_sync[SYNC_STAGES-2:0], bus.jtag_TRSTn};
            tck_prev   <= tck_sync[SYNC_STAGES-1];
        end
    end

    assign tck      = tck_sync[SYNC_STAGES-1];
    assign tms      = tms_sync[SYNC_STAGES-1];
    assign tdi      = tdi_sync[SYNC_STAGES-1];
    assign trst_n   = trstn_sync[SYNC_STAGES-1];
    assign tck_rise = tck & ~tck_prev;
    assign tck_fall = ~tck & tck_prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= TLR;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!trst_n) begin
            state_next = TLR;
        end else if (tck_rise) begin
            case (state)
                TLR:     state_next = tms ? TLR    : RTI;
                RTI:     state_next = tms ? SEL_DR : RTI;
                SEL_DR:  state_next = tms ? SEL_IR : CAP_DR;
                CAP_DR:  state_next = tms ? EX1_DR : SH_DR;
                SH_DR:   state_next = tms ? EX1_DR : SH_DR;
                EX1_DR:  state_next = tms ? UPD_DR : PAU_DR;
                PAU_DR:  state_next = tms ? EX2_DR : PAU_DR;
                EX2_DR:  state_next = tms ? UPD_DR : SH_DR;
                UPD_DR:  state_next = tms ? SEL_DR : RTI;
                SEL_IR:  state_next = tms ? TLR    : CAP_IR;
                CAP_IR:  state_next = tms ? EX1_IR : SH_IR;
                SH_IR:   state_next = tms ? EX1_IR : SH_IR;
                EX1_IR:  state_next = tms ? UPD_IR : PAU_IR;
                PAU_IR:  state_next = tms ? EX2_IR : PAU_IR;
                EX2_IR:  state_next = tms ? UPD_IR : SH_IR;
                UPD_IR:  state_next = tms ? SEL_DR : RTI;
                default: state_next = TLR;
            endcase
        end
    end

    assign user_sel   = (ir_value != IR_IDCODE) && (ir_value != IR_BYPASS);
    assign dr_tdo_mux = (ir_value == IR_IDCODE) ? id_shift[0] :
                        (ir_value == IR_BYPASS) ? bypass_bit  : bus.dr_tdo;

    // A TRSTn-driven reset drops any partial scan, so UpdIR/UpdDR never see it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ir_shift   <= '0;
            ir_value   <= IR_IDCODE;
            id_shift   <= '0;
            bypass_bit <= 1'b0;
            tdo_data   <= 1'b0;
            tdo_driven <= 1'b0;
            dr_capture <= 1'b0;
            dr_shift   <= 1'b0;
            dr_update  <= 1'b0;
        end else begin
            dr_capture <= 1'b0;
            dr_shift   <= 1'b0;
            dr_update  <= 1'b0;
            if (!trst_n) begin
                ir_shift   <= '0;
                ir_value   <= IR_IDCODE;
                id_shift   <= '0;
                bypass_bit <= 1'b0;
                tdo_data   <= 1'b0;
                tdo_driven <= 1'b0;
            end else if (tck_rise) begin
                case (state)
                    CAP_IR: ir_shift <= IR_WIDTH'(1);
                    SH_IR:  ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
                    UPD_IR: ir_value <= ir_shift;
                    CAP_DR: begin
                        id_shift   <= IDCODE_VALUE | 32'd1;
                        bypass_bit <= 1'b0;
                        dr_capture <= user_sel;
                    end
                    SH_DR: begin
                        id_shift   <= {tdi, id_shift[31:1]};
                        bypass_bit <= tdi;
                        dr_shift   <= user_sel;
                    end
                    UPD_DR: dr_update <= user_sel;
                    default: ;
                endcase
                if (state_next == TLR) ir_value <= IR_IDCODE;
            end else if (tck_fall) begin
                tdo_driven <= (state == SH_IR) || (state == SH_DR);
                if (state == SH_IR)      tdo_data <= ir_shift[0];
                else if (state == SH_DR) tdo_data <= dr_tdo_mux;
            end
        end
    end

    assign bus.jtag_TDO_data   = tdo_data;
    assign bus.jtag_TDO_driven = tdo_driven;
    assign bus.tap_state       = state;
    assign bus.ir_value        = ir_value;
    assign bus.user_sel        = user_sel;
    assign bus.dr_capture      = dr_capture;
    assign bus.dr_shift        = dr_shift;
    assign bus.dr_update       = dr_update;
endmodule

// File: doc/jtag_tap_sampler.md
Name: jtag_tap_sampler

Overview:
- Consumes the TCK/TMS/TDI/TRSTn pins produced by the JTAG source (simulation model or FPGA BSCAN bridge) and returns jtag_TDO_data/jtag_TDO_driven to it.
- Oversamples the JTAG pins in the system clock domain and runs an IEEE 1149.1 TAP controller with IR, IDCODE and BYPASS registers.
- Exposes a user data-register strobe interface to the downstream debug transport module.

Parameters:
- IR_WIDTH, 5, instruction register width (minimum 2).
- IDCODE_VALUE, 32'h00000001, value captured by IDCODE. Bit 0 is forced to 1.
- SYNC_STAGES, 2, synchroniser depth for each JTAG input (minimum 2).

Ports:
- clock  in  1  system clock; all state is clocked on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- jtag_TCK  in  1  JTAG clock, treated as data and sampled on clock.
- jtag_TMS  in  1  test mode select.
- jtag_TDI  in  1  test data in.
- jtag_TRSTn  in  1  active-low TAP reset, sampled.
- jtag_TDO_data  out  1  test data out.
- jtag_TDO_driven  out  1  high while TDO is valid (Shift-IR/Shift-DR).
- tap_state  out  4  current TAP state, standard 1149.1 encoding.
- ir_value  out  IR_WIDTH  current instruction.
- user_sel  out  1  the current instruction is neither IDCODE nor BYPASS.
- dr_capture  out  1  one-clock pulse when a TCK rise is taken in Capture-DR and user_sel=1.
- dr_shift  out  1  one-clock pulse when a TCK rise is taken in Shift-DR and user_sel=1.
- dr_update  out  1  one-clock pulse when a TCK rise is taken in Update-DR and user_sel=1.
- dr_tdo  in  1  serial output of the user DR; sampled on the TCK fall.

Behaviour:
- Input synchronisation:
  - TCK, TMS, TDI and TRSTn each pass through SYNC_STAGES flops.
  - tck_prev register holds the previous synced TCK.
  - tck_rise = sync_tck & ~tck_prev; tck_fall = ~sync_tck & tck_prev.
- Timing constraint: TCK high and low phases must each be at least SYNC_STAGES+2 clock periods. Shorter pulses may be lost, and no recovery is required.
- Latency: a pin edge produces its state change SYNC_STAGES+1 clocks later.
- State encoding (hex):
  - TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauDR 3, Ex2DR 0, UpdDR 5.
  - SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauIR B, Ex2IR 8, UpdIR D.
- State transitions: advance only on tck_rise, using synced TMS, per the 1149.1 graph. TMS=1 for 5 consecutive rises reaches TLR from any state.
- Reset values (on reset, or when synced TRSTn=0, asynchronous reset having priority):
  - tap_state=F, ir_value=1 (IDCODE), user_sel=0.
  - TDO_data=0, TDO_driven=0.
  - All pulses 0, all shift registers 0.
  - Synchroniser flops reset to TCK=0, TMS=1, TDI=0, TRSTn=1.
- Entering TLR through TMS also loads ir_value=1.
- IR path:
  - CapIR + tck_rise: ir_shift = {0…0,2'b01}.
  - ShIR + tck_rise: ir_shift = {TDI, ir_shift[IR_WIDTH-1:1]}.
  - UpdIR + tck_rise: ir_value = ir_shift.
- Instructions:
  - 1 = IDCODE (32-bit DR, captures IDCODE_VALUE|1).
  - All-ones = BYPASS (1-bit DR, captures 0).
  - Any other value is a user instruction: user_sel=1 and the DR lives outside this block.
- Internal DRs: capture on CapDR+tck_rise; shift right with TDI into the MSB on ShDR+tck_rise.
- TDO: updated only on tck_fall.
  - In ShIR: TDO_data=ir_shift[0].
  - In ShDR: TDO_data is IDCODE shift[0], the bypass bit, or dr_tdo, according to the instruction.
  - TDO_driven=1 iff the state at that fall is ShIR or ShDR; otherwise TDO_driven=0 and TDO_data holds its last value.
- Strobes: dr_capture/dr_shift/dr_update are registered, occur exactly one clock after the qualifying tck_rise, and last one clock. They are never asserted when user_sel=0.
- Simultaneous events: synced TRSTn=0 overrides any tck_rise in the same clock. A tck_rise and a tck_fall cannot coincide.
- Reset mid-scan: the partial shift content is discarded, ir_value is not updated, and no dr_update pulse is produced.

Test Plan:
- Assert reset 3 clocks, then release -> tap_state=F, ir_value=1, TDO_driven=0, all strobes 0.
- From ShDR, apply TMS=1 for 5 TCKs -> tap_state=F after the 5th rise. 4 TCKs -> not F.
- TLR→RTI→SelDR→CapDR→ShDR, 32 TCKs, IDCODE_VALUE=32'h1234_5677 -> TDO bits read LSB-first = 32'h1234_5677; TDO_driven=1 only during ShDR.
- IR scan shifting in 5'h1F -> captured bits on TDO = 1,0,0,0,0; after UpdIR ir_value=1F. A DR scan of TDI pattern 1,0,1,1 -> TDO = 0,1,0,1 (one-bit delay).
- IR=5'h11, DR scan of 8 bits with dr_tdo toggling -> 1 dr_capture, 8 dr_shift, 1 dr_update pulses; user_sel=1; TDO follows dr_tdo sampled at each TCK fall.
- Drive TRSTn low mid-ShDR (IR=0x11) -> within SYNC_STAGES+1 clocks tap_state=F, ir_value=1, TDO_driven=0, no dr_update. Repeat using async reset -> same result with no clock needed.
